vga_timing_gen: RTL and testbench

- Parametrised raster timing generator for the graphics adapter; successor to the fixed 640x480 counters.
- Produces the items below, all in one clock domain:
  - H/V counters.
  - Active-area coordinates.
  - Sync pulses with programmable polarity.
  - Line and frame strobes.
  - A look-ahead fetch coordinate, FETCH_LEAD pixels early, which covers the screen RAM and character ROM read latency of the mode controllers.
- Pixel rate is set by a clock enable, so the block runs from the system clock.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, active-area decode, syncs, strobes and look-ahead fetch.
// Optional raster interrupt is compiled in when RASTER_IRQ_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int FETCH_LEAD = 2,
    parameter int HW         = 10,
    parameter int VW         = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic [HW-1:0] h_pixel,
    output logic [VW-1:0] line,
    output logic [HW-1:0] posx,
    output logic [VW-1:0] posy,
    output logic          active,
    output logic          h_sync_o,
    output logic          v_sync_o,
    output logic          line_start,
    output logic          frame_start,
    output logic [HW-1:0] fetch_x,
    output logic [VW-1:0] fetch_y,
    output logic          fetch_valid
`ifdef RASTER_IRQ_EN
    ,
    output logic          irq,
    input  logic [VW-1:0] irq_line,
    input  logic          irq_ack
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [HW:0]   HS_BEG  = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   HS_END  = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   VS_BEG  = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   VS_END  = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW:0]   H_TOT_X = (HW+1)'(H_TOTAL);
    localparam logic [HW:0]   LEAD_X  = (HW+1)'(FETCH_LEAD);
    localparam logic [HW-1:0] LEAD_H  = HW'(FETCH_LEAD);
    localparam logic [HW-1:0] HTOT_H  = HW'(H_TOTAL);
    localparam logic          SYNC_ON = (SYNC_POL != 0);

    // Decoded values at (0,0), loaded directly by reset
    localparam logic          RST_ACT = (H_ACTIVE > 0) && (V_ACTIVE > 0);
    localparam logic          RST_FV  = (FETCH_LEAD < H_ACTIVE) && (V_ACTIVE > 0);
    localparam logic [HW-1:0] RST_FX  = RST_FV ? LEAD_H : '0;
    localparam logic          RST_HS  = ((H_ACTIVE + H_FP) == 0) && (H_SYNC > 0) ? SYNC_ON : ~SYNC_ON;
    localparam logic          RST_VS  = ((V_ACTIVE + V_FP) == 0) && (V_SYNC > 0) ? SYNC_ON : ~SYNC_ON;

    logic [HW-1:0] h_q, h_d, posx_q, posx_d, fx_q, fx_d, fx_raw;
    logic [VW-1:0] v_q, v_d, posy_q, posy_d, fy_q, fy_d, fy_raw;
    logic          act_q, act_d, hs_q, hs_d, vs_q, vs_d, fv_q, fv_d;
    logic          ls_q, fs_q, h_wrap, v_wrap;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = h_wrap ? (v_wrap ? '0 : v_q + 1'b1) : v_q;

        act_d  = (h_d < H_ACT) && (v_d < V_ACT);
        posx_d = act_d ? h_d : '0;
        posy_d = act_d ? v_d : '0;
        hs_d   = (({1'b0, h_d} >= HS_BEG) && ({1'b0, h_d} < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vs_d   = (({1'b0, v_d} >= VS_BEG) && ({1'b0, v_d} < VS_END)) ? SYNC_ON : ~SYNC_ON;

        // Look-ahead past the line end lands on the next line; HW-bit wrap arithmetic is exact here
        if (({1'b0, h_d} + LEAD_X) < H_TOT_X) begin
            fx_raw = h_d + LEAD_H;
            fy_raw = v_d;
        end else begin
            fx_raw = h_d + LEAD_H - HTOT_H;
            fy_raw = (v_d == V_LAST) ? '0 : v_d + 1'b1;
        end
        fv_d = (fx_raw < H_ACT) && (fy_raw < V_ACT);
        fx_d = fv_d ? fx_raw : '0;
        fy_d = fv_d ? fy_raw : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= '0;
            v_q    <= '0;
            posx_q <= '0;
            posy_q <= '0;
            act_q  <= RST_ACT;
            hs_q   <= RST_HS;
            vs_q   <= RST_VS;
            fx_q   <= RST_FX;
            fy_q   <= '0;
            fv_q   <= RST_FV;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else if (pix_ce) begin
            h_q    <= h_d;
            v_q    <= v_d;
            posx_q <= posx_d;
            posy_q <= posy_d;
            act_q  <= act_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fx_q   <= fx_d;
            fy_q   <= fy_d;
            fv_q   <= fv_d;
            ls_q   <= h_wrap;
            fs_q   <= h_wrap && v_wrap;
        end else begin
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end
    end

`ifdef RASTER_IRQ_EN
    logic irq_q;

    // Set has priority over a coincident acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (pix_ce && h_wrap && (v_d == irq_line)) begin
            irq_q <= 1'b1;
        end else if (irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

    assign h_pixel     = h_q;
    assign line        = v_q;
    assign posx        = posx_q;
    assign posy        = posy_q;
    assign active      = act_q;
    assign h_sync_o    = hs_q;
    assign v_sync_o    = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign fetch_x     = fx_q;
    assign fetch_y     = fy_q;
    assign fetch_valid = fv_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: default 640x480 timing and a tiny active-high-sync timing,
// both checked against a linear pixel-index reference model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pix_ce, irq_ack;
    logic [9:0] irq_line0;
    logic [2:0] irq_line1;

    logic [9:0] d0_h, d0_v, d0_px, d0_py, d0_fx, d0_fy;
    logic       d0_act, d0_hs, d0_vs, d0_ls, d0_fs, d0_fv;
    logic [3:0] d1_h, d1_px, d1_fx;
    logic [2:0] d1_v, d1_py, d1_fy;
    logic       d1_act, d1_hs, d1_vs, d1_ls, d1_fs, d1_fv;
`ifdef RASTER_IRQ_EN
    logic       d0_irq, d1_irq;
`endif

    vga_timing_gen u_d0 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_pixel(d0_h), .line(d0_v), .posx(d0_px), .posy(d0_py), .active(d0_act),
        .h_sync_o(d0_hs), .v_sync_o(d0_vs), .line_start(d0_ls), .frame_start(d0_fs),
        .fetch_x(d0_fx), .fetch_y(d0_fy), .fetch_valid(d0_fv)
`ifdef RASTER_IRQ_EN
        , .irq(d0_irq), .irq_line(irq_line0), .irq_ack(irq_ack)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .FETCH_LEAD(2), .HW(4), .VW(3)
    ) u_d1 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .h_pixel(d1_h), .line(d1_v), .posx(d1_px), .posy(d1_py), .active(d1_act),
        .h_sync_o(d1_hs), .v_sync_o(d1_vs), .line_start(d1_ls), .frame_start(d1_fs),
        .fetch_x(d1_fx), .fetch_y(d1_fy), .fetch_valid(d1_fv)
`ifdef RASTER_IRQ_EN
        , .irq(d1_irq), .irq_line(irq_line1), .irq_ack(irq_ack)
`endif
    );

    // Timing of each instance, as plain numbers
    int HT[2]  = '{800, 14};
    int VT[2]  = '{525, 7};
    int HA[2]  = '{640, 8};
    int HSB[2] = '{656, 10};
    int HSW[2] = '{96, 2};
    int VA[2]  = '{480, 4};
    int VSB[2] = '{490, 5};
    int VSW[2] = '{2, 1};
    int POL[2] = '{0, 1};
    int LEAD[2] = '{2, 2};

    // Model state: linear pixel index within the frame
    int p[2];
    int ls_m[2], fs_m[2], irq_m[2], irql[2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit meas_on = 1'b0;
    int last_ls0, last_ls1, last_fs1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input int i);
        int fr;
        fr = HT[i] * VT[i];
        if (rst) begin
            p[i] = 0; ls_m[i] = 0; fs_m[i] = 0; irq_m[i] = 0;
        end else if (pix_ce) begin
            p[i] = (p[i] + 1) % fr;
            ls_m[i] = (p[i] % HT[i] == 0) ? 1 : 0;
            fs_m[i] = (p[i] == 0) ? 1 : 0;
            if (irq_ack) irq_m[i] = 0;
            if (ls_m[i] == 1 && p[i] / HT[i] == irql[i]) irq_m[i] = 1;
        end else begin
            ls_m[i] = 0; fs_m[i] = 0;
            if (irq_ack) irq_m[i] = 0;
        end
    endtask

    task automatic compare(input int i, input logic [31:0] h, v, px, py, act, hs, vs,
                           input logic [31:0] ls, fs, fx, fy, fv);
        int eh, ev, ea, q, efx, efy, efv;
        string d;
        d   = $sformatf("d%0d", i);
        eh  = p[i] % HT[i];
        ev  = p[i] / HT[i];
        ea  = (eh < HA[i] && ev < VA[i]) ? 1 : 0;
        q   = (p[i] + LEAD[i]) % (HT[i] * VT[i]);
        efx = q % HT[i];
        efy = q / HT[i];
        efv = (efx < HA[i] && efy < VA[i]) ? 1 : 0;
        check_eq({d, " h_pixel"}, h, eh);
        check_eq({d, " line"}, v, ev);
        check_eq({d, " active"}, act, ea);
        check_eq({d, " posx"}, px, ea ? eh : 0);
        check_eq({d, " posy"}, py, ea ? ev : 0);
        check_eq({d, " h_sync"}, hs, (eh >= HSB[i] && eh < HSB[i] + HSW[i]) ? POL[i] : 1 - POL[i]);
        check_eq({d, " v_sync"}, vs, (ev >= VSB[i] && ev < VSB[i] + VSW[i]) ? POL[i] : 1 - POL[i]);
        check_eq({d, " line_start"}, ls, ls_m[i]);
        check_eq({d, " frame_start"}, fs, fs_m[i]);
        check_eq({d, " fetch_valid"}, fv, efv);
        check_eq({d, " fetch_x"}, fx, efv ? efx : 0);
        check_eq({d, " fetch_y"}, fy, efv ? efy : 0);
    endtask

    task automatic run(input logic r, input logic ce, input logic ack);
        rst = r; pix_ce = ce; irq_ack = ack;
        @(posedge clk);
        #1;
        cyc++;
        model_step(0);
        model_step(1);
        compare(0, 32'(d0_h), 32'(d0_v), 32'(d0_px), 32'(d0_py), 32'(d0_act), 32'(d0_hs),
                32'(d0_vs), 32'(d0_ls), 32'(d0_fs), 32'(d0_fx), 32'(d0_fy), 32'(d0_fv));
        compare(1, 32'(d1_h), 32'(d1_v), 32'(d1_px), 32'(d1_py), 32'(d1_act), 32'(d1_hs),
                32'(d1_vs), 32'(d1_ls), 32'(d1_fs), 32'(d1_fx), 32'(d1_fy), 32'(d1_fv));
`ifdef RASTER_IRQ_EN
        check_eq("d0 irq", 32'(d0_irq), irq_m[0]);
        check_eq("d1 irq", 32'(d1_irq), irq_m[1]);
`endif
        if (meas_on) begin
            if (d0_ls) begin check_eq("d0 line period", cyc - last_ls0, 800); last_ls0 = cyc; end
            if (d1_ls) begin check_eq("d1 line period", cyc - last_ls1, 14); last_ls1 = cyc; end
            if (d1_fs) begin check_eq("d1 frame period", cyc - last_fs1, 98); last_fs1 = cyc; end
        end
    endtask

    initial begin
        int tmp, nxt;
        bit found, r, ce, ack;
        irq_line0 = 10'd1;  irql[0] = 1;
        irq_line1 = 3'd3;   irql[1] = 3;
        p = '{0, 0}; ls_m = '{0, 0}; fs_m = '{0, 0}; irq_m = '{0, 0};

        repeat (3) run(1'b1, 1'b0, 1'b0);
        check_eq("rst d0 active", 32'(d0_act), 1);
        check_eq("rst d0 fetch_x", 32'(d0_fx), 2);
        check_eq("rst d0 fetch_valid", 32'(d0_fv), 1);
        check_eq("rst d0 h_sync", 32'(d0_hs), 1);
        check_eq("rst d1 v_sync", 32'(d1_vs), 0);
        check_eq("rst d0 line_start", 32'(d0_ls), 0);

        // Continuous pixel enable: line and frame periods measured from the strobes
        meas_on = 1'b1;
        last_ls0 = cyc; last_ls1 = cyc; last_fs1 = cyc;
        repeat (2500) run(1'b0, 1'b1, 1'b0);
        meas_on = 1'b0;

        // Pixel enable on alternate clocks
        for (int k = 0; k < 1000; k++) run(1'b0, k[0], 1'b0);

        // Mid-frame reset together with pix_ce on the small timing
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            run(1'b0, 1'b1, 1'b0);
            if (p[1] == 3 * 14 + 5) found = 1'b1;
        end
        check_eq("d1 reached mid-frame", 32'(found), 1);
        run(1'b1, 1'b1, 1'b0);
        check_eq("midrst d1 h_pixel", 32'(d1_h), 0);
        check_eq("midrst d1 active", 32'(d1_act), 1);
        check_eq("midrst d1 h_sync", 32'(d1_hs), 0);
        check_eq("midrst d1 line_start", 32'(d1_ls), 0);

        // Random enables, acks, rare resets, shifting compare line
        for (int k = 0; k < 8000; k++) begin
            if (k % 500 == 0) begin
                tmp = $urandom_range(0, 7);
                irq_line1 = 3'(tmp);
                irql[1] = tmp;
            end
            ce  = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 2999) == 0);
            ack = ($urandom_range(0, 7) == 0);
            nxt = (p[1] + 1) % 98;
            if (!r && ce && nxt % 14 == 0 && nxt / 14 == irql[1]) ack = ($urandom_range(0, 1) == 1);
            run(r, ce, ack);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
